// File: rtl/multicycle_control_if.sv
// multicycle_control_if
// Bundles the controller <-> datapath signals of the multicycle machine.
//   master : the control FSM (reads opCode/mem_ready, drives every strobe/select and state)
//   slave  : the datapath side (drives opCode/mem_ready, reads the strobes)
// Parameters: OPW opcode width, STW state width.
interface multicycle_control_if #(
    parameter int unsigned OPW = 6,
    parameter int unsigned STW = 4
);
    logic [OPW-1:0] opCode;
    logic           mem_ready;
    logic           PCWrite;
    logic           PCWriteCond;
    logic           IorD;
    logic           MemRead;
    logic           MemWrite;
    logic           MemtoReg;
    logic           IRWrite;
    logic [1:0]     PCSource;
    logic [1:0]     ALUOp;
    logic [1:0]     ALUSrcB;
    logic           ALUSrcA;
    logic           RegWrite;
    logic           RegDst;
    logic           illegal_op;
    logic [STW-1:0] state;

    modport master (
        input  opCode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst, illegal_op, state
    );

    modport slave (
        output opCode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst, illegal_op, state
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
// Moore control FSM for the multicycle datapath. Decodes the IR opcode and sequences every
// datapath strobe/select; FETCH, MEMRD and MEMWR wait on mem_ready.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset; while low every strobe is forced to 0, state = FETCH
//   bus   : multicycle_control_if.master (opCode, mem_ready in; strobes, selects, illegal_op,
//           debug state out)
// Configuration: define MULTICYCLE_ADDI_EN to add ADDI (001000) via states ADDIEX(10)/ADDIWB(11);
// otherwise 001000 decodes as illegal.
module multicycle_control #(
    parameter int unsigned OPW = 6,
    parameter int unsigned STW = 4
) (
    input logic                 clk,
    input logic                 reset,
    multicycle_control_if.master bus
);

    localparam logic [OPW-1:0] OpR    = 6'b000000;
    localparam logic [OPW-1:0] OpLw   = 6'b100011;
    localparam logic [OPW-1:0] OpSw   = 6'b101011;
    localparam logic [OPW-1:0] OpBeq  = 6'b000100;
    localparam logic [OPW-1:0] OpJ    = 6'b000010;
`ifdef MULTICYCLE_ADDI_EN
    localparam logic [OPW-1:0] OpAddi = 6'b001000;
`endif

    typedef enum logic [STW-1:0] {
        StFetch   = STW'(0),
        StDecode  = STW'(1),
        StMemAdr  = STW'(2),
        StMemRd   = STW'(3),
        StMemWb   = STW'(4),
        StMemWr   = STW'(5),
        StExec    = STW'(6),
        StRtypeWb = STW'(7),
        StBranch  = STW'(8),
`ifdef MULTICYCLE_ADDI_EN
        StJump    = STW'(9),
        StAddiEx  = STW'(10),
        StAddiWb  = STW'(11)
`else
        StJump    = STW'(9)
`endif
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.PCSource    = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.ALUSrcB     = 2'b00;
        bus.ALUSrcA     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.illegal_op  = 1'b0;

        case (state_q)
            StFetch: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                // IR and PC only load on the cycle the memory actually returns the word
                if (bus.mem_ready) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    state_d     = StDecode;
                end
            end
            StDecode: begin
                bus.ALUSrcB = 2'b11;
                case (bus.opCode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpR:        state_d = StExec;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
`ifdef MULTICYCLE_ADDI_EN
                    OpAddi:     state_d = StAddiEx;
`endif
                    default: begin
                        bus.illegal_op = 1'b1;
                        state_d        = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                if (bus.opCode == OpLw) begin
                    state_d = StMemRd;
                end else if (bus.opCode == OpSw) begin
                    state_d = StMemWr;
                end else begin
                    state_d = StFetch;
                end
            end
            StMemRd: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
                state_d      = StFetch;
            end
            StMemWr: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                if (bus.mem_ready) state_d = StFetch;
            end
            StExec: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
                state_d     = StRtypeWb;
            end
            StRtypeWb: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
                state_d      = StFetch;
            end
            StBranch: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 2'b01;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                state_d         = StFetch;
            end
            StJump: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
                state_d      = StFetch;
            end
`ifdef MULTICYCLE_ADDI_EN
            StAddiEx: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = StAddiWb;
            end
            StAddiWb: begin
                bus.RegWrite = 1'b1;
                state_d      = StFetch;
            end
`endif
            // unused encodings recover to FETCH without strobing anything
            default: state_d = StFetch;
        endcase

        // strobes drop the moment reset asserts, independent of the clock
        if (!reset) begin
            bus.PCWrite     = 1'b0;
            bus.PCWriteCond = 1'b0;
            bus.IorD        = 1'b0;
            bus.MemRead     = 1'b0;
            bus.MemWrite    = 1'b0;
            bus.MemtoReg    = 1'b0;
            bus.IRWrite     = 1'b0;
            bus.PCSource    = 2'b00;
            bus.ALUOp       = 2'b00;
            bus.ALUSrcB     = 2'b00;
            bus.ALUSrcA     = 1'b0;
            bus.RegWrite    = 1'b0;
            bus.RegDst      = 1'b0;
            bus.illegal_op  = 1'b0;
        end
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Table-driven bench for multicycle_control: each record is one clock cycle of
// {opCode, mem_ready} stimulus with the expected state and packed output word, followed by a
// hand-written mid-MEMRD reset sequence.
// Packed output word bit order:
//   [16] PCWrite [15] PCWriteCond [14] IorD [13] MemRead [12] MemWrite [11] MemtoReg
//   [10] IRWrite [9:8] PCSource [7:6] ALUOp [5:4] ALUSrcB [3] ALUSrcA [2] RegWrite
//   [1] RegDst [0] illegal_op
module tb_multicycle_control;

    logic clk;
    logic reset;

    multicycle_control_if #(.OPW(6), .STW(4)) bus ();

    multicycle_control #(.OPW(6), .STW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    //                          PCW   PCWC  IorD  MRd   MWr   M2R   IRW   PCSrc  ALUOp  SrcB   SrcA  RegW  RDst  Ill
    localparam logic [16:0] E_ZERO   = 17'd0;
    localparam logic [16:0] E_FRDY   = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_FWAIT  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_DEC    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_DECILL = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [16:0] E_MADR   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_MRD    = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_MWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [16:0] E_MWR    = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_EXEC   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_RTWB   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [16:0] E_BR     = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_JMP    = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef MULTICYCLE_ADDI_EN
    localparam logic [16:0] E_AEX    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [16:0] E_AWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
`endif

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  exp_state;
        logic [16:0] exp_out;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   n_tests;
    int   n_fail;

    function automatic logic [16:0] outs();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.MemtoReg,
                bus.IRWrite, bus.PCSource, bus.ALUOp, bus.ALUSrcB, bus.ALUSrcA, bus.RegWrite,
                bus.RegDst, bus.illegal_op};
    endfunction

    task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                       input logic [16:0] o, input string name);
        vec_t v;
        v.op        = op;
        v.rdy       = rdy;
        v.exp_state = st;
        v.exp_out   = o;
        v.name      = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] exp_st, input logic [16:0] exp_o);
        n_tests++;
        if (bus.state !== exp_st) begin
            n_fail++;
            $display("FAIL %s state: got %0d expected %0d", name, bus.state, exp_st);
        end
        n_tests++;
        if (outs() !== exp_o) begin
            n_fail++;
            $display("FAIL %s outputs: got %b expected %b", name, outs(), exp_o);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // R-type, no waits
        add(OP_R, 1'b1, 4'd0, E_FRDY, "r_fetch");
        add(OP_R, 1'b1, 4'd1, E_DEC,  "r_decode");
        add(OP_R, 1'b1, 4'd6, E_EXEC, "r_exec");
        add(OP_R, 1'b1, 4'd7, E_RTWB, "r_wb");
        // LW, memory stalls two cycles in MEMRD
        add(OP_LW, 1'b1, 4'd0, E_FRDY, "lw_fetch");
        add(OP_LW, 1'b1, 4'd1, E_DEC,  "lw_decode");
        add(OP_LW, 1'b1, 4'd2, E_MADR, "lw_memadr");
        add(OP_LW, 1'b0, 4'd3, E_MRD,  "lw_memrd_w1");
        add(OP_LW, 1'b0, 4'd3, E_MRD,  "lw_memrd_w2");
        add(OP_LW, 1'b1, 4'd3, E_MRD,  "lw_memrd_rdy");
        add(OP_LW, 1'b1, 4'd4, E_MWB,  "lw_memwb");
        // SW, memory stalls three cycles in FETCH and one in MEMWR
        add(OP_SW, 1'b0, 4'd0, E_FWAIT, "sw_fetch_w1");
        add(OP_SW, 1'b0, 4'd0, E_FWAIT, "sw_fetch_w2");
        add(OP_SW, 1'b0, 4'd0, E_FWAIT, "sw_fetch_w3");
        add(OP_SW, 1'b1, 4'd0, E_FRDY,  "sw_fetch_rdy");
        add(OP_SW, 1'b1, 4'd1, E_DEC,   "sw_decode");
        add(OP_SW, 1'b1, 4'd2, E_MADR,  "sw_memadr");
        add(OP_SW, 1'b0, 4'd5, E_MWR,   "sw_memwr_w1");
        add(OP_SW, 1'b1, 4'd5, E_MWR,   "sw_memwr_rdy");
        // BEQ then J
        add(OP_BEQ, 1'b1, 4'd0, E_FRDY, "beq_fetch");
        add(OP_BEQ, 1'b1, 4'd1, E_DEC,  "beq_decode");
        add(OP_BEQ, 1'b1, 4'd8, E_BR,   "beq_branch");
        add(OP_J,   1'b1, 4'd0, E_FRDY, "j_fetch");
        add(OP_J,   1'b1, 4'd1, E_DEC,  "j_decode");
        add(OP_J,   1'b1, 4'd9, E_JMP,  "j_jump");
        // ADDI
        add(OP_ADDI, 1'b1, 4'd0, E_FRDY, "addi_fetch");
`ifdef MULTICYCLE_ADDI_EN
        add(OP_ADDI, 1'b1, 4'd1,  E_DEC, "addi_decode");
        add(OP_ADDI, 1'b1, 4'd10, E_AEX, "addi_ex");
        add(OP_ADDI, 1'b1, 4'd11, E_AWB, "addi_wb");
`else
        add(OP_ADDI, 1'b1, 4'd1, E_DECILL, "addi_illegal");
`endif
        // Unsupported opcode
        add(OP_BAD, 1'b1, 4'd0, E_FRDY,   "bad_fetch");
        add(OP_BAD, 1'b1, 4'd1, E_DECILL, "bad_decode");
        add(OP_R,   1'b1, 4'd0, E_FRDY,   "after_bad_fetch");

        // Reset state: strobes held at 0 even with mem_ready high and the clock running
        reset         = 1'b0;
        bus.opCode    = OP_R;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("in_reset", 4'd0, E_ZERO);

        // Release with mem_ready low so FETCH holds across the first edge
        @(negedge clk);
        bus.mem_ready = 1'b0;
        reset         = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            bus.opCode    = vecs[i].op;
            bus.mem_ready = vecs[i].rdy;
            @(negedge clk);
            check(vecs[i].name, vecs[i].exp_state, vecs[i].exp_out);
        end

        // Last table row left FETCH with mem_ready=1; walk LW into a stalled MEMRD
        @(posedge clk);
        #1;
        bus.opCode    = OP_LW;
        bus.mem_ready = 1'b0;
        check("rst_seq_decode", 4'd1, E_DEC);
        @(posedge clk);
        #1;
        check("rst_seq_memadr", 4'd2, E_MADR);
        @(posedge clk);
        #1;
        check("rst_seq_memrd", 4'd3, E_MRD);
        // Assert reset between clock edges: strobes must drop without waiting for a clock
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_memrd", 4'd0, E_ZERO);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_release", 4'd0, E_FWAIT);
        @(posedge clk);
        #1;
        check("rst_first_edge", 4'd0, E_FWAIT);
        bus.mem_ready = 1'b1;
        #1;
        check("rst_fetch_rdy", 4'd0, E_FRDY);
        @(posedge clk);
        #1;
        check("rst_decode", 4'd1, E_DEC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
